// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 system bus arbiter and its helpers.
package c64_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BA_WAIT = 2'd1,
      ST_STEAL   = 2'd2
   } arb_state_e;

   localparam int unsigned BA_LEAD_DEFAULT = 3;
   localparam int unsigned VIC_AB_W        = 14;

endpackage

// File: rtl/c64_phi_gen.sv
// Bus phase generator: phi toggles every clk and restarts at phase 0 (VIC) out of reset.
module c64_phi_gen (
   input  logic clk_i,
   input  logic rst_ni,
   output logic phi_o
);

   logic phi_q;
   logic phi_d;

   assign phi_d = ~phi_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phi_q <= 1'b0;
      end else begin
         phi_q <= phi_d;
      end
   end

   assign phi_o = phi_q;

endmodule

// File: rtl/c64_bus_arbiter.sv
// Phase-interleaved CPU/VIC memory bus arbiter with BA/AEC steal handshake.
module c64_bus_arbiter
   import c64_bus_pkg::*;
#(
   parameter int unsigned BA_LEAD = BA_LEAD_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         cpu_ab,
   input  logic [7:0]          cpu_do,
   input  logic                cpu_we,
   output logic                cpu_rdy,
   input  logic                vic_req,
   input  logic [VIC_AB_W-1:0] vic_ab,
   input  logic [1:0]          vic_bank,
   output logic                vic_gnt,
   output logic                vic_ba,
   output logic                aec,
   output logic                phi,
   output logic [15:0]         mem_ab,
   output logic [7:0]          mem_do,
   output logic                mem_we
);

   localparam logic [2:0] LEAD_INIT = 3'(BA_LEAD);

   arb_state_e state_q, state_d;
   logic [2:0] lead_cnt_q, lead_cnt_d;

   c64_phi_gen u_phi_gen (
      .clk_i  (clk),
      .rst_ni (reset),
      .phi_o  (phi)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         lead_cnt_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         lead_cnt_q <= lead_cnt_d;
      end
   end

   // Lead slots are only consumed on edges that close a phase-1 clk; an abort beats the final slot.
   always_comb begin
      state_d    = state_q;
      lead_cnt_d = lead_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (vic_req) begin
               state_d    = ST_BA_WAIT;
               lead_cnt_d = LEAD_INIT;
            end
         end
         ST_BA_WAIT: begin
            if (!vic_req) begin
               state_d = ST_IDLE;
            end else if (phi) begin
               lead_cnt_d = lead_cnt_q - 3'd1;
               if (lead_cnt_q == 3'd1) begin
                  state_d = ST_STEAL;
               end
            end
         end
         ST_STEAL: begin
            if (phi && !vic_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_ab  = {vic_bank, vic_ab};
      mem_do  = cpu_do;
      mem_we  = 1'b0;
      vic_gnt = 1'b1;
      cpu_rdy = 1'b0;
      if (phi && (state_q != ST_STEAL)) begin
         mem_ab  = cpu_ab;
         vic_gnt = 1'b0;
         // During the BA lead only writes complete; reads hold the CPU.
         if ((state_q == ST_IDLE) || cpu_we) begin
            mem_we  = cpu_we;
            cpu_rdy = 1'b1;
         end
      end
   end

   assign vic_ba = (state_q == ST_IDLE);
   assign aec    = (state_q != ST_STEAL);

endmodule
